modport_counter: RTL and testbench



---
 rtl/modport_counter.sv | 32 +++
 tb/tb_modport_counter.sv | 98 +++++++++
 2 files changed

// File: rtl/modport_counter.sv
// Free-running WIDTH-bit up-counter with synchronous active-high reset.
// The count wraps modulo 2**WIDTH. It is driven straight from a register,
// so a monitor sampling at posedge always reads the pre-edge value.
module modport_counter #(
    parameter int unsigned         WIDTH       = 4,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             rst_h,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Increment with the carry dropped, which gives the wrap from all-ones to zero.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
    end

    // Count register: reset has priority over the increment and is sampled only at the edge.
    always_ff @(posedge clock) begin
        if (rst_h) begin
            cnt_q <= RESET_VALUE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: tb/tb_modport_counter.sv
// Directed and random-reset checks for modport_counter (WIDTH=4, RESET_VALUE=0).
module tb_modport_counter;

    logic       clock;
    logic       rst_h;
    logic [3:0] out;

    int n_checks;
    int n_fail;
    logic [3:0] model;

    modport_counter #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (
        .clock (clock),
        .rst_h (rst_h),
        .out   (out)
    );

    // 10 time-unit clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive rst_h on the falling edge, then sample 1 unit after the rising edge.
    task automatic step(input logic r);
        @(negedge clock);
        rst_h = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_h    = 1'b1;

        // Reset held for two edges
        step(1'b1); check("reset_edge1", out, 4'h0);
        step(1'b1); check("reset_edge2", out, 4'h0);

        // Release and count 1..5
        for (int i = 1; i <= 5; i++) begin
            step(1'b0);
            check($sformatf("count_%0d", i), out, 4'(i));
        end

        // A reset pulse that lands entirely between edges has no effect
        #2 rst_h = 1'b1;
        #2 rst_h = 1'b0;
        @(posedge clock); #1;
        check("glitch_ignored", out, 4'h6);

        // Wrap: 16 edges from reset gives 0, the 17th gives 1
        step(1'b1); check("wrap_reset", out, 4'h0);
        for (int i = 1; i <= 15; i++) step(1'b0);
        check("wrap_at_15", out, 4'hF);
        step(1'b0); check("wrap_16th", out, 4'h0);
        step(1'b0); check("wrap_17th", out, 4'h1);

        // Mid-count reset at 9
        step(1'b1);
        for (int i = 1; i <= 9; i++) step(1'b0);
        check("mid_at_9", out, 4'h9);
        step(1'b1); check("mid_reset", out, 4'h0);
        step(1'b0); check("mid_resume", out, 4'h1);

        // Reset at max value, held for 3 edges
        step(1'b1);
        for (int i = 1; i <= 15; i++) step(1'b0);
        check("max_at_15", out, 4'hF);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1);
            check($sformatf("max_reset_hold_%0d", i), out, 4'h0);
        end
        step(1'b0); check("max_resume", out, 4'h1);

        // Random reset (~10% high) against a reference model
        model = 4'h1;
        for (int i = 0; i < 1000; i++) begin
            logic r;
            r = ($urandom_range(0, 9) == 0);
            step(r);
            model = r ? 4'h0 : model + 4'h1;
            check("random", out, model);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
